// File: rtl/booth_sched_pkg.sv
// Shared definitions for the Booth multiplier scheduler: FSM state encoding,
// default parameter values and a small width helper.
package booth_sched_pkg;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_WIDTH_IN       = 16;
  localparam int DEF_WIDTH_PROD     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  // Index width that stays legal for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_mult_scheduler_if.sv
// Request, multiplier and response bundle of the scheduler.
// slave = scheduler side, master = requesters/multiplier/consumer side.
interface booth_mult_scheduler_if
  import booth_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int WIDTH_IN   = DEF_WIDTH_IN,
  parameter int WIDTH_PROD = DEF_WIDTH_PROD
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*WIDTH_IN-1:0] req_a;
  logic [NUM_REQ*WIDTH_IN-1:0] req_b;
  logic                        mul_start;
  logic [WIDTH_IN-1:0]         mul_a;
  logic [WIDTH_IN-1:0]         mul_b;
  logic                        mul_done;
  logic [WIDTH_PROD-1:0]       mul_product;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_W-1:0]             rsp_id;
  logic [WIDTH_PROD-1:0]       rsp_product;
  logic                        rsp_err;
  logic                        busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_done, mul_product, rsp_ready,
    output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id,
           rsp_product, rsp_err, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_done, mul_product, rsp_ready,
    input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id,
           rsp_product, rsp_err, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: remembers the last served index and grants the first
// asserted request after it, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W-1:0] last_reg, last_next;
  logic [ID_W-1:0] cand;

  always_comb begin
    last_next = update ? ptr : last_reg;
  end

  // Last = NUM_REQ-1 out of reset so requester 0 has top priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_reg <= ID_W'(NUM_REQ - 1);
    else        last_reg <= last_next;
  end

  always_comb begin
    grant = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_reg) + k) % NUM_REQ);
      if (grant == '0 && req[cand]) grant[cand] = 1'b1;
    end
  end

endmodule

// File: rtl/booth_mult_scheduler.sv
// Shares one start/done multiplier among NUM_REQ requesters: round-robin
// accept, launch, bounded wait for completion, then hold the response.
module booth_mult_scheduler
  import booth_sched_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int WIDTH_IN       = DEF_WIDTH_IN,
  parameter int WIDTH_PROD     = DEF_WIDTH_PROD,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                   clk,
  input logic                   reset,
  booth_mult_scheduler_if.slave bus
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t          state_reg, state_next;
  logic [WIDTH_IN-1:0]   a_reg, a_next;
  logic [WIDTH_IN-1:0]   b_reg, b_next;
  logic [ID_W-1:0]       id_reg, id_next;
  logic [WIDTH_PROD-1:0] prod_reg, prod_next;
  logic                  err_reg, err_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  arb_update;
  logic [WIDTH_IN-1:0]   a_arr [NUM_REQ];
  logic [WIDTH_IN-1:0]   b_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = bus.req_a[gi*WIDTH_IN +: WIDTH_IN];
      assign b_arr[gi] = bus.req_b[gi*WIDTH_IN +: WIDTH_IN];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.req_valid),
    .ptr    (id_reg),
    .update (arb_update),
    .grant  (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = ID_W'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    id_next    = id_reg;
    prod_next  = prod_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    arb_update = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A grant only exists on an asserted valid, so it is the transfer.
        if (|grant) begin
          a_next     = a_arr[grant_idx];
          b_next     = b_arr[grant_idx];
          id_next    = grant_idx;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // Completion takes precedence over expiry in the final wait cycle.
        if (bus.mul_done) begin
          prod_next  = bus.mul_product;
          err_next   = 1'b0;
          state_next = ST_RESP;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          prod_next  = '0;
          err_next   = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          arb_update = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      id_reg    <= '0;
      prod_reg  <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      id_reg    <= id_next;
      prod_reg  <= prod_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign bus.req_ready   = (state_reg == ST_IDLE) ? grant : '0;
  assign bus.mul_start   = (state_reg == ST_ISSUE);
  assign bus.mul_a       = a_reg;
  assign bus.mul_b       = b_reg;
  assign bus.rsp_valid   = (state_reg == ST_RESP);
  assign bus.rsp_id      = id_reg;
  assign bus.rsp_product = prod_reg;
  assign bus.rsp_err     = err_reg;
  assign bus.busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Scoreboard bench for booth_mult_scheduler with a delay-programmable
// multiplier model answering mul_start.
module tb_booth_mult_scheduler;
  import booth_sched_pkg::*;

  localparam int NR = 4;
  localparam int WI = 16;
  localparam int WP = 32;
  localparam int TO = 40;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] prod;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } op_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  booth_mult_scheduler_if #(.NUM_REQ(NR), .WIDTH_IN(WI), .WIDTH_PROD(WP)) bus ();

  booth_mult_scheduler #(
    .NUM_REQ(NR), .WIDTH_IN(WI), .WIDTH_PROD(WP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mul_delay = 3;
  int cd        = -1;
  int start_cyc = 0;
  int acc_count = 0;
  int rsp_count = 0;
  int acc_cyc   = 0;
  int rsp_cyc   = 0;
  int exp_g;
  int base;
  logic        prev_rv;
  logic [31:0] last_prod;
  logic        last_err;
  logic [1:0]  last_id;
  logic signed [31:0] prod_hold;
  logic [15:0] a_stim [NR];
  logic [15:0] b_stim [NR];
  exp_t exp_q [$];
  op_t  op_q [$];
  int   grant_q [$];
  exp_t e_acc, e_rsp;
  op_t  op_acc, op_mul;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    a_stim[i] = a;
    b_stim[i] = b;
    bus.req_a[i*WI +: WI] = a;
    bus.req_b[i*WI +: WI] = b;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int k = 0;
    while (acc_count < target && k < budget) begin
      @(posedge clk); #1; k++;
    end
    check_eq("accept_wait", 64'(acc_count >= target), 64'd1);
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int k = 0;
    while (rsp_count < target && k < budget) begin
      @(posedge clk); #1; k++;
    end
    check_eq("rsp_wait", 64'(rsp_count >= target), 64'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: answers each launch after mul_delay cycles (<0 = never).
  initial begin
    bus.mul_done    = 1'b0;
    bus.mul_product = '0;
    forever begin
      @(negedge clk);
      bus.mul_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.mul_done    = 1'b1;
          bus.mul_product = prod_hold;
          cd = -1;
        end
      end
      if (reset && bus.mul_start) begin
        start_cyc = cyc;
        if (op_q.size() > 0) begin
          op_mul = op_q.pop_front();
          check_eq("mul_a", 64'(bus.mul_a), 64'(op_mul.a));
          check_eq("mul_b", 64'(bus.mul_b), 64'(op_mul.b));
        end
        prod_hold = $signed(bus.mul_a) * $signed(bus.mul_b);
        cd = (mul_delay < 0) ? -1 : mul_delay;
      end
    end
  end

  // Accept side pushes expectations; response side pops and compares.
  initial begin
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < NR; i++) begin
          if (bus.req_valid[i] && bus.req_ready[i]) begin
            acc_count++;
            acc_cyc = cyc;
            check_eq("ready_onehot", 64'($onehot(bus.req_ready)), 64'd1);
            exp_g = -1;
            if (grant_q.size() > 0) exp_g = grant_q.pop_front();
            check_eq("grant_id", 64'(i), 64'(exp_g));
            e_acc.id  = 2'(i);
            e_acc.err = (mul_delay < 0 || mul_delay > TO);
            if (e_acc.err) begin
              e_acc.prod = 32'd0;
              e_acc.lat  = TO + 1;
            end else begin
              e_acc.prod = $signed(a_stim[i]) * $signed(b_stim[i]);
              e_acc.lat  = mul_delay + 1;
            end
            exp_q.push_back(e_acc);
            op_acc.a = a_stim[i];
            op_acc.b = b_stim[i];
            op_q.push_back(op_acc);
          end
        end
        if (bus.rsp_valid && !prev_rv && exp_q.size() > 0)
          check_eq("rsp_latency", 64'(cyc - start_cyc), 64'(exp_q[0].lat));
        if (bus.rsp_valid && bus.rsp_ready) begin
          rsp_count++;
          rsp_cyc   = cyc;
          last_prod = bus.rsp_product;
          last_err  = bus.rsp_err;
          last_id   = bus.rsp_id;
          if (exp_q.size() > 0) begin
            e_rsp = exp_q.pop_front();
            $display("rsp id=%0d product=0x%08h err=%0d", bus.rsp_id, bus.rsp_product, bus.rsp_err);
            check_eq("rsp_id", 64'(bus.rsp_id), 64'(e_rsp.id));
            check_eq("rsp_product", 64'(bus.rsp_product), 64'(e_rsp.prod));
            check_eq("rsp_err", 64'(bus.rsp_err), 64'(e_rsp.err));
          end else begin
            check_eq("rsp_unexpected", 64'(exp_q.size()), 64'd1);
          end
        end
        prev_rv = bus.rsp_valid;
      end else begin
        prev_rv = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) set_op(i, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_mul_start", 64'(bus.mul_start), 64'd0);
    check_eq("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check_eq("rst_rsp_product", 64'(bus.rsp_product), 64'd0);
    check_eq("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check_eq("rst_mul_ab", 64'({bus.mul_a, bus.mul_b}), 64'd0);
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single request from requester 2: 3 * -5, done 17 cycles after start.
    set_op(2, 16'd3, 16'hFFFB);
    mul_delay = 17;
    grant_q.push_back(2);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    base = rsp_count;
    wait_acc(acc_count + 1, 10);
    bus.req_valid = '0;
    wait_rsp(base + 1, 100);
    check_eq("single_product", 64'(last_prod), 64'hFFFF_FFF1);
    check_eq("single_id", 64'(last_id), 64'd2);

    // All requesters valid from reset release: service order 0,1,2,3,0.
    reset = 1'b0;
    set_op(0, 16'd7, 16'd11);
    set_op(1, 16'hFFFF, 16'd300);
    set_op(2, 16'h8000, 16'h8000);
    set_op(3, 16'd1234, 16'hFF00);
    bus.req_valid = 4'b1111;
    mul_delay = 3;
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
    grant_q.push_back(3); grant_q.push_back(0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    base = rsp_count;
    wait_rsp(base + 5, 200);
    bus.req_valid = '0;

    // Held response: fields stable and no new grant for 10 cycles.
    set_op(1, 16'd100, 16'hFF38);
    set_op(3, 16'hFFF0, 16'd5);
    mul_delay = 5;
    grant_q.push_back(1); grant_q.push_back(3);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1010;
    base = rsp_count;
    wait_acc(acc_count + 1, 10);
    bus.req_valid = 4'b1000;
    for (int k = 0; k < 30 && !bus.rsp_valid; k++) begin
      @(posedge clk); #1;
    end
    check_eq("hold_reach_resp", 64'(bus.rsp_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      check_eq("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check_eq("hold_rsp_id", 64'(bus.rsp_id), 64'd1);
      check_eq("hold_rsp_product", 64'(bus.rsp_product), 64'hFFFF_B1E0);
      check_eq("hold_rsp_err", 64'(bus.rsp_err), 64'd0);
      check_eq("hold_req_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    wait_rsp(base + 1, 10);
    wait_acc(acc_count + 1, 10);
    bus.req_valid = '0;
    check_eq("back_to_back", 64'(acc_cyc - rsp_cyc), 64'd1);
    wait_rsp(base + 2, 100);

    // No completion at all: error response after the full wait window.
    set_op(1, 16'd9, 16'd9);
    mul_delay = -1;
    grant_q.push_back(1);
    bus.req_valid = 4'b0010;
    base = rsp_count;
    wait_acc(acc_count + 1, 10);
    bus.req_valid = '0;
    wait_rsp(base + 1, 100);
    check_eq("timeout_err", 64'(last_err), 64'd1);
    check_eq("timeout_product", 64'(last_prod), 64'd0);

    // Completion in the last wait cycle beats expiry.
    set_op(2, 16'hFFF9, 16'd9);
    mul_delay = TO;
    grant_q.push_back(2);
    bus.req_valid = 4'b0100;
    base = rsp_count;
    wait_acc(acc_count + 1, 10);
    bus.req_valid = '0;
    wait_rsp(base + 1, 100);
    check_eq("tie_err", 64'(last_err), 64'd0);
    check_eq("tie_product", 64'(last_prod), 64'hFFFF_FFC1);

    // Reset while waiting: in-flight request dropped, late done ignored.
    set_op(0, 16'd21, 16'd2);
    mul_delay = 20;
    grant_q.push_back(0);
    bus.req_valid = 4'b0001;
    wait_acc(acc_count + 1, 10);
    bus.req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("pre_reset_busy", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("mid_reset_busy", 64'(bus.busy), 64'd0);
    check_eq("mid_reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    base = rsp_count;
    repeat (30) @(posedge clk);
    #1;
    check_eq("late_done_no_rsp", 64'(rsp_count), 64'(base));
    check_eq("late_done_busy", 64'(bus.busy), 64'd0);
    check_eq("late_done_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    check_eq("sb_empty", 64'(exp_q.size() + op_q.size() + grant_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mult_scheduler.md
BOOTH_MULT_SCHEDULER -- requirements
Module: booth_mult_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one Booth multiplier.
REQ-002 Parameter WIDTH_IN, default 16: operand width.
REQ-003 Parameter WIDTH_PROD, default 32: product width, equal to 2*WIDTH_IN.
REQ-004 Parameter TIMEOUT_CYCLES, default 40: maximum cycles spent in WAIT before an error response.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester operation request.
REQ-008 req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 req_a  input  NUM_REQ*WIDTH_IN  packed multiplicands; requester i occupies slice i.
REQ-010 req_b  input  NUM_REQ*WIDTH_IN  packed multipliers; requester i occupies slice i.
REQ-011 mul_start  output  1  one-cycle launch pulse to the multiplier.
REQ-012 mul_a, mul_b  output  WIDTH_IN each  operands to the multiplier, stable from mul_start until response.
REQ-013 mul_done  input  1  multiplier completion pulse.
REQ-014 mul_product  input  WIDTH_PROD  multiplier result, valid with mul_done.
REQ-015 rsp_valid  output  1  response available.
REQ-016 rsp_ready  input  1  consumer accepts response.
REQ-017 rsp_id  output  $clog2(NUM_REQ)  index of the served requester.
REQ-018 rsp_product  output  WIDTH_PROD  signed product.
REQ-019 rsp_err  output  1  timeout flag; rsp_product is 0 when set.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: round-robin grant among asserted req_valid bits; search starts at last-granted index + 1, modulo NUM_REQ.
REQ-023 IDLE: req_ready asserted combinationally for the granted index only; all req_ready bits are 0 outside IDLE.
REQ-024 Transfer occurs when req_valid[i] & req_ready[i]; operands and id are latched; next state is ISSUE.
REQ-025 IDLE with no req_valid bit set: remain in IDLE; pointer unchanged.
REQ-026 ISSUE: mul_start = 1 for exactly one cycle; next state is WAIT; cycle counter cleared.
REQ-027 WAIT: counter increments each cycle; mul_done = 1 captures mul_product, rsp_err = 0, next state RESP.
REQ-028 WAIT: if counter reaches TIMEOUT_CYCLES with no mul_done, go to RESP with rsp_err = 1 and rsp_product = 0.
REQ-029 mul_done and counter expiry in the same cycle: mul_done wins; rsp_err = 0.
REQ-030 mul_done outside WAIT is ignored.
REQ-031 RESP: rsp_valid = 1; rsp_id, rsp_product and rsp_err stay stable until rsp_ready = 1.
REQ-032 RESP with rsp_ready = 1: return to IDLE; round-robin pointer updates to the granted index.
REQ-033 Minimum latency: accept at cycle 0, mul_start at cycle 1, rsp_valid the cycle after mul_done.
REQ-034 Back-to-back operation: a new grant is possible in the cycle after the response handshake.

Reset
REQ-035 reset low: state goes to IDLE immediately, regardless of the current state.
REQ-036 Output reset values: mul_start, rsp_valid, rsp_err and busy are 0; rsp_product, rsp_id, mul_a and mul_b are 0; the counter is 0.
REQ-037 After reset, the round-robin pointer selects requester 0 as highest priority.
REQ-038 Reset mid-operation discards the in-flight request; no response is produced.

Structure
REQ-039 The shared package booth_sched_pkg holds the state enum and the default parameter constants.
REQ-040 The round-robin arbiter is a separate sub-module, rr_arbiter (request vector, pointer and update in; one-hot grant out).
REQ-041 A multiplier with a start/done handshake connects directly to mul_* without extra glue logic.

Verification
REQ-042 Single request: req 2, a=3, b=-5; mul_done 17 cycles after start with -15 -> rsp_id=2, rsp_product=0xFFFFFFF1, rsp_err=0.
REQ-043 All four requesters held valid continuously from reset -> service order 0,1,2,3,0.
REQ-044 mul_done never arrives -> rsp_err=1 and rsp_product=0 exactly 40 cycles after entering WAIT.
REQ-045 rsp_ready held low for 10 cycles in RESP -> response fields stay stable and req_ready stays 0 throughout.
REQ-046 reset asserted during WAIT -> busy=0 and rsp_valid=0 immediately; a later mul_done produces no response.
REQ-047 mul_done coincides with timeout expiry -> rsp_err=0 and rsp_product equals the captured mul_product.
